// File: rtl/rand_pkg.sv
// Shared types and helpers for the random range sampler.
// Holds the sampler FSM state type, the default LFSR width and the
// fill-down mask function used to build the rejection mask.
package rand_pkg;

  localparam int LFSR_W_DEF = 17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_SAMPLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } sampler_state_t;

  // All ones from the most significant set bit of d down to bit 0; zero when d is zero.
  function automatic logic [LFSR_W_DEF-1:0] span_mask(input logic [LFSR_W_DEF-1:0] d);
    logic [LFSR_W_DEF-1:0] m;
    m = '0;
    for (int i = 0; i < LFSR_W_DEF; i++) begin
      m[i] = |(d >> i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_mask_gen.sv
// Combinational range decode for the sampler: span (hi-lo+1, one bit wider
// than the bounds so a full range fits), the fill-down rejection mask for
// (hi-lo), and the inverted-range flag.
module rand_mask_gen
  import rand_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic [OUT_W-1:0] lo,
  input  logic [OUT_W-1:0] hi,
  output logic [OUT_W:0]   span,
  output logic [OUT_W-1:0] mask,
  output logic             inv
);

  logic [OUT_W-1:0]      diff;
  logic [LFSR_W_DEF-1:0] diff_ext;
  logic [LFSR_W_DEF-1:0] mask_wide;
  logic                  unused_mask_hi;

  // Range arithmetic; span and mask are meaningless when the range is inverted.
  always_comb begin
    diff      = hi - lo;
    diff_ext  = LFSR_W_DEF'(diff);
    mask_wide = span_mask(diff_ext);
    mask      = mask_wide[OUT_W-1:0];
    span      = {1'b0, hi} - {1'b0, lo} + (OUT_W+1)'(1);
    inv       = (hi < lo);
  end

  assign unused_mask_hi = ^(mask_wide >> OUT_W);

endmodule

// File: rtl/rand_range_sampler.sv
// Uniform integer sampler over an inclusive range [lo, hi] using
// mask-and-reject on the low bits of a free-running LFSR state.
// Optional statistics counters are built when RAND_SAMPLER_STATS_EN is defined.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; once valid is raised the producer holds it and the payload
// stable until that edge. req_ready is registered and only high in IDLE;
// rsp_valid is registered and only high in RESP.
module rand_range_sampler
  import rand_pkg::*;
#(
  parameter int OUT_W     = 10,
  parameter int LFSR_W    = LFSR_W_DEF,
  parameter int MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] lfsr_q,
  output logic              lfsr_adv,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OUT_W-1:0]  req_lo,
  input  logic [OUT_W-1:0]  req_hi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_W-1:0]  rsp_value,
  output logic              rsp_fallback,
  output sampler_state_t    dbg_state
`ifdef RAND_SAMPLER_STATS_EN
  ,
  output logic [15:0]       stat_rejects,
  output logic [15:0]       stat_fallbacks
`endif
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  sampler_state_t   state;
  logic [OUT_W-1:0] lo_q;
  logic [OUT_W-1:0] hi_q;
  logic [OUT_W:0]   span_q;
  logic [OUT_W-1:0] mask_q;
  logic             inv_q;
  logic [TRY_W-1:0] tries;

  logic [OUT_W:0]   gen_span;
  logic [OUT_W-1:0] gen_mask;
  logic             gen_inv;

  logic [OUT_W-1:0] cand;
  logic [OUT_W:0]   cand_ext;
  logic [OUT_W:0]   wrap_off;
  logic             last_try;
  logic             take_inv;
  logic             take_ok;
  logic             take_fb;
  logic             do_reject;
  logic             unused_lfsr_hi;

  rand_mask_gen #(.OUT_W(OUT_W)) u_mask_gen (
    .lo   (lo_q),
    .hi   (hi_q),
    .span (gen_span),
    .mask (gen_mask),
    .inv  (gen_inv)
  );

  // Candidate draw and the decision taken for it while in SAMPLE.
  always_comb begin
    cand      = lfsr_q[OUT_W-1:0] & mask_q;
    cand_ext  = {1'b0, cand};
    wrap_off  = cand_ext - span_q;
    last_try  = (tries == TRY_W'(MAX_TRIES - 1));
    take_inv  = (state == S_SAMPLE) && inv_q;
    take_ok   = (state == S_SAMPLE) && !inv_q && (cand_ext < span_q);
    take_fb   = (state == S_SAMPLE) && !inv_q && !(cand_ext < span_q) && last_try;
    do_reject = (state == S_SAMPLE) && !inv_q && !(cand_ext < span_q) && !last_try;
  end

  assign unused_lfsr_hi = ^(lfsr_q >> OUT_W);
  assign dbg_state      = state;

  // Sampler FSM with registered handshake outputs and advance strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      span_q       <= '0;
      mask_q       <= '0;
      inv_q        <= 1'b0;
      tries        <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_value    <= '0;
      rsp_fallback <= 1'b0;
      lfsr_adv     <= 1'b0;
    end else begin
      lfsr_adv <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lo_q      <= req_lo;
            hi_q      <= req_hi;
            tries     <= '0;
            req_ready <= 1'b0;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          span_q   <= gen_span;
          mask_q   <= gen_mask;
          inv_q    <= gen_inv;
          lfsr_adv <= 1'b1;
          state    <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (take_inv) begin
            rsp_value    <= lo_q;
            rsp_fallback <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else if (take_ok) begin
            rsp_value    <= lo_q + cand;
            rsp_fallback <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else if (take_fb) begin
            // cand < 2*span, so folding once lands inside the range.
            rsp_value    <= lo_q + wrap_off[OUT_W-1:0];
            rsp_fallback <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            tries <= tries + TRY_W'(1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          lfsr_adv <= 1'b1;
          state    <= S_SAMPLE;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAND_SAMPLER_STATS_EN
  // Saturating counts of rejected draws and fallback responses since reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rejects   <= '0;
      stat_fallbacks <= '0;
    end else begin
      if (do_reject && stat_rejects != 16'hFFFF) begin
        stat_rejects <= stat_rejects + 16'd1;
      end
      if ((take_inv || take_fb) && stat_fallbacks != 16'hFFFF) begin
        stat_fallbacks <= stat_fallbacks + 16'd1;
      end
    end
  end
`else
  logic unused_reject;
  assign unused_reject = do_reject;
`endif

endmodule
